lcd_char_writer: RTL and testbench

Drives an HD44780-compatible 16x2 character LCD in 8-bit write-only mode. It consumes ASCII codes from the keypad decoder, such as the digit codes 8'h30–8'h39 and blank 8'h20. It runs the power-on init sequence, writes each accepted character at the cursor, and manages line wrap and clear. It sits between the keypad/calculator datapath and the LCD pins.

---
 rtl/lcd_pkg.sv | 46 ++++
 rtl/lcd_byte_xfer.sv | 127 ++++++++++++
 rtl/lcd_char_writer.sv | 173 +++++++++++++++++
 tb/tb_lcd_char_writer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg
// Shared definitions for the HD44780 character writer: the LCD command
// bytes, the top-level sequencer states, the byte-transfer phases and a
// small helper for sizing the wait counters.
package lcd_pkg;

  localparam logic [7:0] LCD_FUNC_SET = 8'h38;
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_ENTRY    = 8'h06;
  localparam logic [7:0] LCD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_LINE1    = 8'h80;
  localparam logic [7:0] LCD_LINE2    = 8'hC0;

  localparam logic [2:0] INIT_CMD_COUNT = 3'd4;

  typedef enum logic [1:0] {
    ST_PWRUP,
    ST_INIT,
    ST_IDLE,
    ST_XFER
  } lcdState_t;

  typedef enum logic [2:0] {
    XP_IDLE,
    XP_SETUP,
    XP_PULSE,
    XP_HOLD,
    XP_WAIT
  } xferPhase_t;

  // Power-on command list, issued in index order.
  function automatic logic [7:0] initCmd(input logic [2:0] idx);
    case (idx)
      3'd0:    initCmd = LCD_FUNC_SET;
      3'd1:    initCmd = LCD_DISP_ON;
      3'd2:    initCmd = LCD_ENTRY;
      3'd3:    initCmd = LCD_CLEAR;
      default: initCmd = 8'h00;
    endcase
  endfunction

  function automatic int maxOf(input int a, input int b);
    maxOf = (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_byte_xfer.sv
// lcd_byte_xfer
// Moves one byte onto the LCD pins using the SETUP / PULSE / HOLD / WAIT
// sequence, then signals completion. A new start is accepted while idle or
// in the final WAIT cycle, so consecutive bytes follow with no gap.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   i_start         begin a transfer with i_rs / i_data / i_longWait
//   i_rs            register select for this byte (0 command, 1 data)
//   i_data          byte to place on the bus
//   i_longWait      use CLR_WAIT instead of CMD_WAIT after the strobe
//   o_lcdE          enable strobe
//   o_lcdRs         register select pin
//   o_lcdData       data bus pins
//   o_done          high during the last WAIT cycle of a transfer
module lcd_byte_xfer
  import lcd_pkg::*;
#(
  parameter int E_PULSE  = 12,
  parameter int CMD_WAIT = 2500,
  parameter int CLR_WAIT = 100000,
  parameter int CNT_W    = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic       i_rs,
  input  logic [7:0] i_data,
  input  logic       i_longWait,
  output logic       o_lcdE,
  output logic       o_lcdRs,
  output logic [7:0] o_lcdData,
  output logic       o_done
);

  xferPhase_t         r_phase;
  xferPhase_t         w_nextPhase;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_nextCnt;
  logic [CNT_W-1:0]   w_waitLast;
  logic               r_e;
  logic               r_rs;
  logic [7:0]         r_data;
  logic               r_long;
  logic               w_done;
  logic               w_load;

  // The wait length is chosen by the byte currently in flight, so it is
  // taken from the latched flag rather than the live input.
  always_comb begin
    w_waitLast = r_long ? CNT_W'(CLR_WAIT - 1) : CNT_W'(CMD_WAIT - 1);
    w_done     = (r_phase == XP_WAIT) && (r_cnt == w_waitLast);
    w_load     = i_start && ((r_phase == XP_IDLE) || w_done);
  end

  // Phase sequencing; the shared counter times both the strobe width and
  // the post-strobe wait, restarting from zero on every phase change.
  always_comb begin
    w_nextPhase = r_phase;
    w_nextCnt   = r_cnt;
    case (r_phase)
      XP_IDLE: begin
        if (w_load) begin
          w_nextPhase = XP_SETUP;
          w_nextCnt   = '0;
        end
      end
      XP_SETUP: begin
        w_nextPhase = XP_PULSE;
        w_nextCnt   = '0;
      end
      XP_PULSE: begin
        if (r_cnt == CNT_W'(E_PULSE - 1)) begin
          w_nextPhase = XP_HOLD;
          w_nextCnt   = '0;
        end else begin
          w_nextCnt = r_cnt + 1'b1;
        end
      end
      XP_HOLD: begin
        w_nextPhase = XP_WAIT;
        w_nextCnt   = '0;
      end
      XP_WAIT: begin
        if (w_done) begin
          w_nextPhase = w_load ? XP_SETUP : XP_IDLE;
          w_nextCnt   = '0;
        end else begin
          w_nextCnt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_nextPhase = XP_IDLE;
        w_nextCnt   = '0;
      end
    endcase
  end

  // Enable is registered from the next phase so it is glitch-free and drops
  // together with the async reset. Bus and RS are captured only on a new
  // start and otherwise hold through HOLD and WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase <= XP_IDLE;
      r_cnt   <= '0;
      r_e     <= 1'b0;
      r_rs    <= 1'b0;
      r_data  <= 8'h00;
      r_long  <= 1'b0;
    end else begin
      r_phase <= w_nextPhase;
      r_cnt   <= w_nextCnt;
      r_e     <= (w_nextPhase == XP_PULSE);
      if (w_load) begin
        r_rs   <= i_rs;
        r_data <= i_data;
        r_long <= i_longWait;
      end
    end
  end

  assign o_lcdE    = r_e;
  assign o_lcdRs   = r_rs;
  assign o_lcdData = r_data;
  assign o_done    = w_done;

endmodule

// File: rtl/lcd_char_writer.sv
// lcd_char_writer
// Drives a 16x2 HD44780 LCD in 8-bit write-only mode: runs the power-on
// init sequence, writes accepted ASCII characters at the cursor, tracks
// the column and repositions the cursor on line changes, and handles
// clear requests.
//
// Ports:
//   clk, rst   system clock, asynchronous active-high reset
//   i_char     ASCII code to write
//   i_valid    i_char is valid
//   i_clr      clear request, sampled while idle, wins over i_valid
//   o_ready    high only while idle; a character is taken on
//              i_valid && o_ready && !i_clr
//   lcd_rs     0 command, 1 data
//   lcd_rw     always 0 (write only)
//   lcd_e      enable strobe
//   lcd_data   LCD data bus
module lcd_char_writer
  import lcd_pkg::*;
#(
  parameter int E_PULSE   = 12,
  parameter int CMD_WAIT  = 2500,
  parameter int CLR_WAIT  = 100000,
  parameter int INIT_WAIT = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_char,
  input  logic       i_valid,
  input  logic       i_clr,
  output logic       o_ready,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data
);

  localparam int CNT_W = $clog2(maxOf(INIT_WAIT, CLR_WAIT) + 1);

  lcdState_t         r_state;
  lcdState_t         w_nextState;
  logic [CNT_W-1:0]  r_pwrCnt;
  logic [2:0]        r_initIdx;
  logic [4:0]        r_col;
  logic              r_wrapPend;
  logic [7:0]        r_wrapCmd;
  logic              r_ready;
  logic              w_start;
  logic              w_rs;
  logic [7:0]        w_data;
  logic              w_long;
  logic              w_done;
  logic              w_accept;
  logic              w_clrTake;

  assign w_clrTake = (r_state == ST_IDLE) && i_clr;
  assign w_accept  = (r_state == ST_IDLE) && !i_clr && i_valid;
  assign w_long    = !w_rs && (w_data == LCD_CLEAR);

  // Next-state and byte selection. Starts are issued combinationally so
  // an idle request lands in SETUP on the accepting edge, and chained
  // bytes (init list, cursor moves) start in the last WAIT cycle of the
  // previous byte without a gap.
  always_comb begin
    w_nextState = r_state;
    w_start     = 1'b0;
    w_rs        = 1'b0;
    w_data      = 8'h00;
    case (r_state)
      ST_PWRUP: begin
        if (r_pwrCnt == CNT_W'(INIT_WAIT - 1)) begin
          w_start     = 1'b1;
          w_data      = initCmd(3'd0);
          w_nextState = ST_INIT;
        end
      end
      ST_INIT: begin
        if (w_done) begin
          if (r_initIdx < INIT_CMD_COUNT) begin
            w_start = 1'b1;
            w_data  = initCmd(r_initIdx);
          end else begin
            w_nextState = ST_IDLE;
          end
        end
      end
      ST_IDLE: begin
        if (i_clr) begin
          w_start     = 1'b1;
          w_data      = LCD_CLEAR;
          w_nextState = ST_XFER;
        end else if (i_valid) begin
          w_start     = 1'b1;
          w_rs        = 1'b1;
          w_data      = i_char;
          w_nextState = ST_XFER;
        end
      end
      ST_XFER: begin
        if (w_done) begin
          if (r_wrapPend) begin
            w_start = 1'b1;
            w_data  = r_wrapCmd;
          end else begin
            w_nextState = ST_IDLE;
          end
        end
      end
      default: w_nextState = ST_PWRUP;
    endcase
  end

  // State register plus bookkeeping: power-up delay, init list index,
  // the cursor column and the pending cursor-move command that a
  // character crossing a line boundary leaves behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_PWRUP;
      r_pwrCnt   <= '0;
      r_initIdx  <= 3'd0;
      r_col      <= 5'd0;
      r_wrapPend <= 1'b0;
      r_wrapCmd  <= 8'h00;
      r_ready    <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_ready <= (w_nextState == ST_IDLE);
      if (r_state == ST_PWRUP) begin
        r_pwrCnt <= r_pwrCnt + 1'b1;
      end
      if (w_start && ((r_state == ST_PWRUP) || (r_state == ST_INIT))) begin
        r_initIdx <= r_initIdx + 1'b1;
      end
      if (w_clrTake) begin
        r_col      <= 5'd0;
        r_wrapPend <= 1'b0;
      end else if (w_accept) begin
        r_col <= r_col + 5'd1;
        if (r_col == 5'd15) begin
          r_wrapPend <= 1'b1;
          r_wrapCmd  <= LCD_LINE2;
        end else if (r_col == 5'd31) begin
          r_wrapPend <= 1'b1;
          r_wrapCmd  <= LCD_LINE1;
        end
      end else if ((r_state == ST_XFER) && w_done && r_wrapPend) begin
        r_wrapPend <= 1'b0;
      end
    end
  end

  lcd_byte_xfer #(
    .E_PULSE  (E_PULSE),
    .CMD_WAIT (CMD_WAIT),
    .CLR_WAIT (CLR_WAIT),
    .CNT_W    (CNT_W)
  ) u_xfer (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_start),
    .i_rs       (w_rs),
    .i_data     (w_data),
    .i_longWait (w_long),
    .o_lcdE     (lcd_e),
    .o_lcdRs    (lcd_rs),
    .o_lcdData  (lcd_data),
    .o_done     (w_done)
  );

  assign o_ready = r_ready;
  assign lcd_rw  = 1'b0;

endmodule

// File: tb/tb_lcd_char_writer.sv
// tb_lcd_char_writer
// Directed bench for lcd_char_writer with shortened timing
// (E_PULSE=2, CMD_WAIT=4, CLR_WAIT=10, INIT_WAIT=20). A monitor logs every
// enable strobe as {rs, data} and checks the bus stays put while enable
// is high; the sequences below compare that log and the handshake timing
// against hand-computed values.
module tb_lcd_char_writer;

  localparam int E_PULSE   = 2;
  localparam int CMD_WAIT  = 4;
  localparam int CLR_WAIT  = 10;
  localparam int INIT_WAIT = 20;

  typedef struct {
    logic [7:0] ch;
    logic       hasCmd;
    logic [7:0] cmd;
    int         expCycles;
    int         expCol;
  } wrapVec_t;

  logic       clk;
  logic       rst;
  logic [7:0] i_char;
  logic       i_valid;
  logic       i_clr;
  logic       o_ready;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic [7:0] lcd_data;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [8:0] strobes[$];
  logic [8:0] held;
  logic       prevE;
  wrapVec_t   wrapTbl[32];
  logic [8:0] initExp[4];
  logic [7:0] b2bChars[3];
  int         acc[3];

  lcd_char_writer #(
    .E_PULSE   (E_PULSE),
    .CMD_WAIT  (CMD_WAIT),
    .CLR_WAIT  (CLR_WAIT),
    .INIT_WAIT (INIT_WAIT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_char   (i_char),
    .i_valid  (i_valid),
    .i_clr    (i_clr),
    .o_ready  (o_ready),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_e    (lcd_e),
    .lcd_data (lcd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] ch, input logic valid, input logic clr);
    i_char  = ch;
    i_valid = valid;
    i_clr   = clr;
  endtask

  // Counts rising edges until o_ready is seen high just after an edge.
  task automatic waitReady(input string name, input int limit, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!o_ready && n < limit);
    if (!o_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: got o_ready=0 after %0d cycles, expected 1", name, n);
    end
  endtask

  task automatic checkStrobe(input string name, input int idx, input logic [8:0] exp);
    if (strobes.size() > idx)
      checkOutput(name, 32'(strobes[idx]), 32'(exp));
    else
      checkOutput(name, 32'h1ff_ffff, 32'(exp));
  endtask

  // Releases reset and checks the four init commands and their duration.
  task automatic runInit(input string name);
    int n;
    @(negedge clk);
    strobes.delete();
    rst = 1'b0;
    waitReady(name, 200, n);
    checkOutput({name, "_ready_cycles"}, 32'(n), 32'd58);
    checkOutput({name, "_strobe_count"}, 32'(strobes.size()), 32'd4);
    for (int i = 0; i < 4; i++) checkStrobe({name, "_cmd"}, i, initExp[i]);
  endtask

  task automatic sendChar(input logic [7:0] ch, output int n);
    @(negedge clk);
    applyStimulus(ch, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    applyStimulus(8'h00, 1'b0, 1'b0);
    waitReady("send_char", 100, n);
  endtask

  // Strobe logger and bus-stability check while enable is high.
  always @(negedge clk) begin
    if (rst) begin
      prevE = 1'b0;
    end else begin
      if (lcd_e && !prevE) begin
        strobes.push_back({lcd_rs, lcd_data});
        held = {lcd_rs, lcd_data};
      end else if (lcd_e) begin
        checkOutput("strobe_stable", 32'({lcd_rs, lcd_data}), 32'(held));
      end
      prevE = lcd_e;
    end
  end

  // Hard stop in case a sequence wedges.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b1;
    applyStimulus(8'h00, 1'b0, 1'b0);
    initExp = '{9'h038, 9'h00C, 9'h006, 9'h001};
    b2bChars = '{8'h41, 8'h42, 8'h43};
    for (int i = 0; i < 32; i++) begin
      wrapTbl[i].ch        = 8'h30 + 8'(i % 10);
      wrapTbl[i].hasCmd    = (i == 15) || (i == 31);
      wrapTbl[i].cmd       = (i == 15) ? 8'hC0 : 8'h80;
      wrapTbl[i].expCycles = wrapTbl[i].hasCmd ? 16 : 8;
      wrapTbl[i].expCol    = (i + 1) % 32;
    end

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_lcd_e", 32'(lcd_e), 32'd0);
    checkOutput("rst_lcd_rs", 32'(lcd_rs), 32'd0);
    checkOutput("rst_lcd_rw", 32'(lcd_rw), 32'd0);
    checkOutput("rst_lcd_data", 32'(lcd_data), 32'h00);
    checkOutput("rst_o_ready", 32'(o_ready), 32'd0);
    checkOutput("rst_col", 32'(dut.r_col), 32'd0);

    runInit("init");
    $display("[TB] init sequence done at cycle %0d", cyc);

    // Single character: SETUP after edge T, strobe after T+1 and T+2,
    // HOLD after T+3, ready again after T+8 (sampled at edge T+9).
    @(negedge clk);
    strobes.delete();
    applyStimulus(8'h35, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    applyStimulus(8'h00, 1'b0, 1'b0);
    checkOutput("char_setup_rs", 32'(lcd_rs), 32'd1);
    checkOutput("char_setup_data", 32'(lcd_data), 32'h35);
    checkOutput("char_setup_e", 32'(lcd_e), 32'd0);
    checkOutput("char_ready_drop", 32'(o_ready), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (k == 1 || k == 2) checkOutput("char_pulse_e", 32'(lcd_e), 32'd1);
      if (k == 3) begin
        checkOutput("char_hold_e", 32'(lcd_e), 32'd0);
        checkOutput("char_hold_data", 32'(lcd_data), 32'h35);
      end
      if (k == 7) checkOutput("char_ready_early", 32'(o_ready), 32'd0);
      if (k == 8) checkOutput("char_ready", 32'(o_ready), 32'd1);
    end
    checkOutput("char_strobe_count", 32'(strobes.size()), 32'd1);
    checkStrobe("char_strobe", 0, 9'h135);
    checkOutput("char_col", 32'(dut.r_col), 32'd1);

    // Clear wins over a coincident character, which stays pending.
    @(negedge clk);
    strobes.delete();
    applyStimulus(8'h37, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    i_clr = 1'b0;
    checkOutput("clr_col", 32'(dut.r_col), 32'd0);
    waitReady("clr", 100, n);
    checkOutput("clr_ready_cycles", 32'(n), 32'd14);
    checkOutput("clr_strobe_count", 32'(strobes.size()), 32'd1);
    checkStrobe("clr_strobe", 0, 9'h001);
    @(posedge clk);
    #1;
    applyStimulus(8'h00, 1'b0, 1'b0);
    checkOutput("pending_char_data", 32'(lcd_data), 32'h37);
    checkOutput("pending_char_rs", 32'(lcd_rs), 32'd1);
    checkOutput("pending_ready_drop", 32'(o_ready), 32'd0);
    waitReady("pending", 100, n);
    checkOutput("pending_ready_cycles", 32'(n), 32'd8);
    checkOutput("pending_strobe_count", 32'(strobes.size()), 32'd2);
    checkStrobe("pending_strobe", 1, 9'h137);
    checkOutput("pending_col", 32'(dut.r_col), 32'd1);

    // Plain clear to home the cursor before the wrap walk.
    @(negedge clk);
    applyStimulus(8'h00, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    applyStimulus(8'h00, 1'b0, 1'b0);
    waitReady("clr2", 100, n);
    checkOutput("clr2_ready_cycles", 32'(n), 32'd14);
    checkOutput("clr2_col", 32'(dut.r_col), 32'd0);

    // Line wrap walk: 32 characters from the table.
    for (int i = 0; i < 32; i++) begin
      strobes.delete();
      sendChar(wrapTbl[i].ch, n);
      checkOutput("wrap_ready_cycles", 32'(n), 32'(wrapTbl[i].expCycles));
      checkOutput("wrap_strobe_count", 32'(strobes.size()), wrapTbl[i].hasCmd ? 32'd2 : 32'd1);
      checkStrobe("wrap_char", 0, {1'b1, wrapTbl[i].ch});
      if (wrapTbl[i].hasCmd) checkStrobe("wrap_cmd", 1, {1'b0, wrapTbl[i].cmd});
      checkOutput("wrap_col", 32'(dut.r_col), 32'(wrapTbl[i].expCol));
    end

    // Back-to-back with i_valid held high across three characters.
    strobes.delete();
    for (int k = 0; k < 3; k++) begin
      int guard;
      guard = 0;
      @(negedge clk);
      while (!o_ready && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (!o_ready) checkOutput("b2b_ready_timeout", 32'(o_ready), 32'd1);
      applyStimulus(b2bChars[k], 1'b1, 1'b0);
      @(posedge clk);
      #1;
      acc[k] = cyc;
    end
    @(negedge clk);
    applyStimulus(8'h00, 1'b0, 1'b0);
    waitReady("b2b", 100, n);
    checkOutput("b2b_gap1", 32'(acc[1] - acc[0]), 32'd9);
    checkOutput("b2b_gap2", 32'(acc[2] - acc[1]), 32'd9);
    checkOutput("b2b_strobe_count", 32'(strobes.size()), 32'd3);
    for (int k = 0; k < 3; k++) checkStrobe("b2b_strobe", k, {1'b1, b2bChars[k]});

    // Reset while the enable strobe is high.
    @(negedge clk);
    applyStimulus(8'h39, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    applyStimulus(8'h00, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("midrst_pulse_before", 32'(lcd_e), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_lcd_e", 32'(lcd_e), 32'd0);
    checkOutput("midrst_o_ready", 32'(o_ready), 32'd0);
    checkOutput("midrst_lcd_data", 32'(lcd_data), 32'h00);
    checkOutput("midrst_lcd_rs", 32'(lcd_rs), 32'd0);
    checkOutput("midrst_col", 32'(dut.r_col), 32'd0);
    repeat (2) @(posedge clk);
    runInit("reinit");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
